// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: master SPI sequencer for one 1-8 bit character with SCLK divider, edge counter, CS and shift registers.
module spi_xfer_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       tx_data,
  input  logic [2:0]       char_len,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] clk_div,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rx_data,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, clk_div_q, clk_div_d;
  logic [4:0] edge_q, edge_d;
  logic [2:0] len_q, len_d;
  logic cpol_q, cpol_d, cpha_q, cpha_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
  logic [3:0] n_in, n_l;
  logic [7:0] tx_al;
  logic tick, last_edge, lead;
  assign n_in = (char_len == 3'd0) ? 4'd8 : {1'b0, char_len};
  assign n_l = (len_q == 3'd0) ? 4'd8 : {1'b0, len_q};
  // left-align the character so the first bit out is always tx_sh[7]
  assign tx_al = tx_data << (4'd8 - n_in);
  assign tick = (state_q != IDLE) && (div_q == clk_div_q);
  assign last_edge = tick && (edge_q == {n_l, 1'b0} - 5'd1);
  assign lead = ~edge_q[0];
  assign busy = state_q != IDLE;
  assign cs_n = state_q == IDLE;
  assign done = done_q;
  assign rx_data = rx_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  always_comb begin
    state_d = state_q;
    div_d = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
    clk_div_d = clk_div_q;
    edge_d = edge_q;
    len_d = len_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx_d = rx_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (start && !done_q) begin
          state_d = SETUP;
          clk_div_d = clk_div;
          len_d = char_len;
          cpol_d = cpol;
          cpha_d = cpha;
          tx_sh_d = tx_al;
          rx_sh_d = '0;
          edge_d = '0;
          mosi_d = cpha ? mosi_q : tx_al[7];
        end
      end
      SETUP: if (tick) begin
        state_d = XFER;
        edge_d = '0;
      end
      XFER: if (tick) begin
        sclk_d = ~sclk_q;
        edge_d = edge_q + 5'd1;
        if (lead ^ cpha_q) rx_sh_d = {rx_sh_q[6:0], miso};
        else if (!last_edge) begin
          mosi_d = cpha_q ? tx_sh_q[7] : tx_sh_q[6];
          tx_sh_d = tx_sh_q << 1;
        end
        if (last_edge) begin
          state_d = HOLD;
          edge_d = '0;
        end
      end
      HOLD: begin
        sclk_d = cpol_q;
        if (tick) begin
          state_d = IDLE;
          done_d = 1'b1;
          rx_d = rx_sh_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      clk_div_q <= '0;
      edge_q <= '0;
      len_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      clk_div_q <= clk_div_d;
      edge_q <= edge_d;
      len_q <= len_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_q <= rx_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: directed self-checking bench for spi_xfer_ctrl.
module tb_spi_xfer_ctrl;
  logic clk = 1'b0;
  logic rst, start, cpol, cpha, busy, done, sclk, mosi, miso, cs_n, loop_en, miso_v;
  logic [7:0] tx_data, rx_data, clk_div;
  logic [2:0] char_len;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  assign miso = loop_en ? mosi : miso_v;
  spi_xfer_ctrl #(.DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .char_len(char_len),
    .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .busy(busy), .done(done),
    .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic [7:0] tx, input logic [2:0] len, input logic pol, input logic pha,
                      input logic [7:0] div, input logic lp, input logic dbl, input logic [7:0] exp_rx,
                      input int exp_busy, input logic exp_mosi);
    int busy_n, tg, dn, csm, n;
    logic prev, mosi_l;
    n = (len == 3'd0) ? 8 : int'(len);
    tx_data = tx; char_len = len; cpol = pol; cpha = pha; clk_div = div; loop_en = lp;
    @(negedge clk);
    check("idle_sclk", sclk, pol);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; tg = 0; dn = 0; csm = 0; prev = pol; mosi_l = 1'bx;
    for (int i = 0; i < exp_busy + 4; i++) begin
      if (busy) busy_n++;
      if (sclk != prev) begin
        tg++;
        if (tg == 1) mosi_l = mosi;
      end
      prev = sclk;
      if (done) dn++;
      if (cs_n == busy) csm++;
      start = dbl && (i == 3 || i == 10 || done);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", busy_n, exp_busy);
    check("sclk_edges", tg, 2 * n);
    check("done_pulses", dn, 1);
    check("cs_vs_busy", csm, 0);
    check("rx_data", rx_data, exp_rx);
    check("first_mosi", mosi_l, exp_mosi);
  endtask
  initial begin
    int tg, i;
    logic prev;
    rst = 1'b1; start = 1'b0; tx_data = '0; char_len = '0; cpol = 1'b0; cpha = 1'b0;
    clk_div = '0; loop_en = 1'b1; miso_v = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_rx", rx_data, 0);
    rst = 1'b0;
    @(negedge clk);
    xfer(8'hA5, 3'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 8'hA5, 36, 1'b1);
    xfer(8'h16, 3'd5, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 8'h16, 12, 1'b1);
    miso_v = 1'b1;
    xfer(8'hFF, 3'd3, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 8'h07, 24, 1'b1);
    xfer(8'h5A, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 8'h5A, 18, 1'b0);
    xfer(8'h09, 3'd4, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 8'h09, 20, 1'b1);
    xfer(8'h03, 3'd1, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0, 8'h01, 1024, 1'b1);
    tx_data = 8'hA5; char_len = 3'd0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; loop_en = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prev = sclk; tg = 0; i = 0;
    while (tg < 7 && i < 100) begin
      @(negedge clk);
      if (sclk != prev) tg++;
      prev = sclk;
      i++;
    end
    check("rst_edge_reached", tg, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_rx", rx_data, 0);
    check("mid_rst_done", done, 0);
    repeat (40) begin
      @(negedge clk);
      if (done || busy) break;
    end
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
